proc_fl: RTL and testbench
==========================

# proc_fl

Functional-level (instruction-per-cycle) TinyRV1 processor model with a unified internal memory and CSR-mapped I/O ports. It is the golden reference core: the pipelined RTL processors are checked against it instruction by instruction via its trace interface. Test benches preload program and data by writing the internal memory array `M` hierarchically before releasing reset.

## Interface
- No parameters.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset; one clock, reset is asynchronous and active-high.
- `in0`, `in1`, `in2`  in  32  values read by `csrr` from CSRs 0xFC2, 0xFC3, 0xFC4.
- `out0`, `out1`, `out2`  out  32  registers written by `csrw` to CSRs 0x7C2, 0x7C3, 0x7C4.
- `trace_val`  out  1  an instruction executes this cycle.
- `trace_addr`  out  32  PC of that instruction.
- `trace_inst`  out  32  its encoding.
- `trace_data`  out  32  value written to the destination (register or out CSR), else all-x.
- Internal: `M`, 32-bit words indexed directly by byte address, entries 0x0000–0x3FFF; only word-aligned addresses are used; no reset.

## Operation
- State: `PC` (32 b), `R[0:31]` (32 b, `R[0]` reads 0, writes ignored), `out0..2`, `M`.
- Every non-reset cycle fetches `M[PC]` and executes exactly one instruction (standard RV32 encodings):
  - `add rd,rs1,rs2`: `R[rd]=R[rs1]+R[rs2]`, PC+4.
  - `addi rd,rs1,imm`: `R[rd]=R[rs1]+sext(imm12)`, PC+4; wraps mod 2^32.
  - `mul rd,rs1,rs2`: low 32 bits of product, PC+4.
  - `lw rd,imm(rs1)`: `R[rd]=M[R[rs1]+sext(imm)]`, PC+4.
  - `sw rs2,imm(rs1)`: `M[R[rs1]+sext(imm)]=R[rs2]`, PC+4; `trace_data` is x.
  - `jal rd,imm`: `R[rd]=PC+4`, `PC=PC+sext(imm21)`.
  - `jr rs1`: `PC=R[rs1]`; `trace_data` is x.
  - `bne rs1,rs2,imm`: `PC=PC+sext(imm13)` if unequal, else PC+4; `trace_data` is x.
  - `csrr rd,csr`: `R[rd]=inN`, PC+4.
  - `csrw csr,rs1`: `outN=R[rs1]`, PC+4; `trace_data` is the written value.
- `trace_data` for a register-writing instruction equals the result even when `rd`=x0.
- Unrecognised instruction or CSR number: no state change except PC+4, `trace_data` x.
- Memory addresses outside 0x0000–0x3FFF: loads return 0, stores are dropped.

## Timing
- While `rst`=1: `PC`=0, all `R`=0, `out0..2`=0, `trace_val`=0, `trace_addr/inst/data`=0.
- First instruction (address 0x000) is presented in the first cycle after `rst` falls.
- Trace outputs are combinational from the current PC and state, valid for the whole cycle. All state updates at the next rising edge. CPI = 1; `trace_val`=1 every non-reset cycle.
- Reads within an instruction see pre-instruction state; a write is visible to the next instruction (no hazards).
- `rst` asserted mid-program aborts the current instruction immediately; memory is retained.

## Configuration
- `PROC_FL_DISPLAY_EN`: when defined, each executed instruction issues one `$display` line with cycle count, PC, raw instruction and `trace_data`. When undefined, no simulation output; functional behaviour is identical.

## Test plan
- Reset: hold `rst` 3 cycles -> `trace_val`=0, `out0..2`=0; first traced `trace_addr`=0x000.
- `addi x1,x0,5`; `addi x2,x1,-1`; `csrw out0,x2` -> traces (0x000,5), (0x004,4), (0x008,4); `out0`=4.
- `addi x3,x0,0x7FF`; `addi x3,x3,1` -> data 0x7FF then 0x800; `addi x4,x0,-2048` -> 0xFFFFF800.
- `addi x0,x0,9` then `add x5,x0,x0` -> data 9, then 0 (x0 unchanged).
- `csrr x1,in0` with `in0`=0x12; `sw x1,0x100(x0)`; `lw x2,0x100(x0)` -> data 0x12, x, 0x12.
- Loop: `addi x1,x0,3`; `addi x1,x1,-1`; `bne x1,x0,-4`; `jal x7,8` -> addrs 0,4,8,4,8,4,8,0xC; jal data 0x10; next PC 0x14.

Source files
------------

// File: rtl/proc_fl.sv
// rtl/proc_fl.sv - functional-level TinyRV1 core, one instruction per cycle; optional PROC_FL_DISPLAY_EN trace printing
module proc_fl (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] in0,
   input  logic [31:0] in1,
   input  logic [31:0] in2,
   output logic [31:0] out0,
   output logic [31:0] out1,
   output logic [31:0] out2,
   output logic        trace_val,
   output logic [31:0] trace_addr,
   output logic [31:0] trace_inst,
   output logic [31:0] trace_data
);

   localparam logic [31:0] MEM_LIMIT = 32'h0000_4000;

   // Unified memory indexed by byte address; benches preload it hierarchically.
   logic [31:0] M [0:16383];
   logic [31:0] R [0:31];
   logic [31:0] pc;

   logic [31:0] inst;
   logic [6:0]  opcode;
   logic [4:0]  rd, rs1, rs2;
   logic [2:0]  funct3;
   logic [6:0]  funct7;
   logic [11:0] csr;
   logic [31:0] rs1_val, rs2_val;
   logic [31:0] imm_i, imm_s, imm_b, imm_j;
   logic [31:0] ld_addr, st_addr, ld_data;

   logic [31:0] next_pc;
   logic        rf_we;
   logic [31:0] wb_data;
   logic        st_we;
   logic [2:0]  out_we;
   logic [31:0] data_x;

   assign inst    = (pc < MEM_LIMIT) ? M[pc[13:0]] : '0;
   assign opcode  = inst[6:0];
   assign rd      = inst[11:7];
   assign funct3  = inst[14:12];
   assign rs1     = inst[19:15];
   assign rs2     = inst[24:20];
   assign funct7  = inst[31:25];
   assign csr     = inst[31:20];
   assign rs1_val = R[rs1];
   assign rs2_val = R[rs2];
   assign imm_i   = {{20{inst[31]}}, inst[31:20]};
   assign imm_s   = {{20{inst[31]}}, inst[31:25], inst[11:7]};
   assign imm_b   = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
   assign imm_j   = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
   assign ld_addr = rs1_val + imm_i;
   assign st_addr = rs1_val + imm_s;
   // Out-of-range loads read as zero rather than aliasing into the array.
   assign ld_data = (ld_addr < MEM_LIMIT) ? M[ld_addr[13:0]] : '0;

   // Decode and execute the instruction at PC; unknown encodings only advance PC.
   always_comb begin
      next_pc = pc + 32'd4;
      rf_we   = 1'b0;
      wb_data = '0;
      st_we   = 1'b0;
      out_we  = 3'b000;
      data_x  = 'x;
      case (opcode)
         7'h33: begin
            if (funct3 == 3'b000 && funct7 == 7'h00) begin
               rf_we = 1'b1; wb_data = rs1_val + rs2_val; data_x = wb_data;
            end else if (funct3 == 3'b000 && funct7 == 7'h01) begin
               rf_we = 1'b1; wb_data = rs1_val * rs2_val; data_x = wb_data;
            end
         end
         7'h13: if (funct3 == 3'b000) begin
            rf_we = 1'b1; wb_data = rs1_val + imm_i; data_x = wb_data;
         end
         7'h03: if (funct3 == 3'b010) begin
            rf_we = 1'b1; wb_data = ld_data; data_x = wb_data;
         end
         7'h23: if (funct3 == 3'b010) begin
            st_we = (st_addr < MEM_LIMIT);
         end
         7'h6F: begin
            rf_we = 1'b1; wb_data = pc + 32'd4; data_x = wb_data;
            next_pc = pc + imm_j;
         end
         7'h67: if (funct3 == 3'b000) begin
            next_pc = rs1_val;
         end
         7'h63: if (funct3 == 3'b001) begin
            if (rs1_val != rs2_val) next_pc = pc + imm_b;
         end
         7'h73: begin
            if (funct3 == 3'b010) begin
               case (csr)
                  12'hFC2: begin rf_we = 1'b1; wb_data = in0; data_x = in0; end
                  12'hFC3: begin rf_we = 1'b1; wb_data = in1; data_x = in1; end
                  12'hFC4: begin rf_we = 1'b1; wb_data = in2; data_x = in2; end
                  default: ;
               endcase
            end else if (funct3 == 3'b001) begin
               case (csr)
                  12'h7C2: begin out_we = 3'b001; data_x = rs1_val; end
                  12'h7C3: begin out_we = 3'b010; data_x = rs1_val; end
                  12'h7C4: begin out_we = 3'b100; data_x = rs1_val; end
                  default: ;
               endcase
            end
         end
         default: ;
      endcase
   end

   assign trace_val  = ~rst;
   assign trace_addr = rst ? '0 : pc;
   assign trace_inst = rst ? '0 : inst;
   assign trace_data = rst ? '0 : data_x;

   // Architectural state: PC, register file and output CSRs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc   <= '0;
         out0 <= '0;
         out1 <= '0;
         out2 <= '0;
         for (int i = 0; i < 32; i++) R[i] <= '0;
      end else begin
         pc <= next_pc;
         if (rf_we && rd != 5'd0) R[rd] <= wb_data;
         if (out_we[0]) out0 <= rs1_val;
         if (out_we[1]) out1 <= rs1_val;
         if (out_we[2]) out2 <= rs1_val;
      end
   end

   // Memory has no reset so preloaded contents survive a mid-program reset.
   always_ff @(posedge clk) begin
      if (!rst && st_we) M[st_addr[13:0]] <= rs2_val;
   end

`ifdef PROC_FL_DISPLAY_EN
   logic [31:0] cycle_cnt;

   // Print one line per executed instruction.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cycle_cnt <= '0;
      end else begin
         cycle_cnt <= cycle_cnt + 32'd1;
         $display("cyc %0d pc %h inst %h data %h", cycle_cnt, pc, inst, data_x);
      end
   end
`else
`endif

endmodule

// File: tb/tb_proc_fl.sv
// tb/tb_proc_fl.sv - scoreboard bench for proc_fl trace and CSR outputs
module tb_proc_fl;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] in0, in1, in2;
   logic [31:0] out0, out1, out2;
   logic        trace_val;
   logic [31:0] trace_addr, trace_inst, trace_data;

   int tests  = 0;
   int failed = 0;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] inst;
      logic [31:0] data;
      bit          dx;
   } exp_t;

   exp_t sb[$];

   proc_fl dut (
      .clk(clk), .rst(rst),
      .in0(in0), .in1(in1), .in2(in2),
      .out0(out0), .out1(out1), .out2(out2),
      .trace_val(trace_val), .trace_addr(trace_addr),
      .trace_inst(trace_inst), .trace_data(trace_data)
   );

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [31:0] e_addi(input logic [4:0] rd, input logic [4:0] rs1, input logic [31:0] imm);
      return {imm[11:0], rs1, 3'b000, rd, 7'h13};
   endfunction
   function automatic logic [31:0] e_add(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
      return {7'h00, rs2, rs1, 3'b000, rd, 7'h33};
   endfunction
   function automatic logic [31:0] e_mul(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
      return {7'h01, rs2, rs1, 3'b000, rd, 7'h33};
   endfunction
   function automatic logic [31:0] e_lw(input logic [4:0] rd, input logic [4:0] rs1, input logic [31:0] imm);
      return {imm[11:0], rs1, 3'b010, rd, 7'h03};
   endfunction
   function automatic logic [31:0] e_sw(input logic [4:0] rs2, input logic [4:0] rs1, input logic [31:0] imm);
      return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'h23};
   endfunction
   function automatic logic [31:0] e_jal(input logic [4:0] rd, input logic [31:0] imm);
      return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6F};
   endfunction
   function automatic logic [31:0] e_jr(input logic [4:0] rs1);
      return {12'd0, rs1, 3'b000, 5'd0, 7'h67};
   endfunction
   function automatic logic [31:0] e_bne(input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm);
      return {imm[12], imm[10:5], rs2, rs1, 3'b001, imm[4:1], imm[11], 7'h63};
   endfunction
   function automatic logic [31:0] e_csrr(input logic [4:0] rd, input logic [11:0] csr);
      return {csr, 5'd0, 3'b010, rd, 7'h73};
   endfunction
   function automatic logic [31:0] e_csrw(input logic [11:0] csr, input logic [4:0] rs1);
      return {csr, rs1, 3'b001, 5'd0, 7'h73};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic expect_trace(input logic [31:0] a, input logic [31:0] i, input logic [31:0] d, input bit dx);
      exp_t e;
      e.addr = a; e.inst = i; e.data = d; e.dx = dx;
      sb.push_back(e);
   endtask

   task automatic put(input logic [31:0] a, input logic [31:0] i, input logic [31:0] d, input bit dx);
      dut.M[a[13:0]] = i;
      expect_trace(a, i, d, dx);
   endtask

   task automatic clear_mem();
      for (int a = 0; a < 16384; a++) dut.M[a] = '0;
   endtask

   task automatic run_sb(input string name);
      int n = 0;
      exp_t e;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         #1;
         chk($sformatf("%s[%0d].val",  name, n), {31'd0, trace_val}, 32'd1);
         chk($sformatf("%s[%0d].addr", name, n), trace_addr, e.addr);
         chk($sformatf("%s[%0d].inst", name, n), trace_inst, e.inst);
         if (!e.dx) chk($sformatf("%s[%0d].data", name, n), trace_data, e.data);
         n++;
         @(negedge clk);
      end
   endtask

   initial begin
      rst = 1'b1;
      in0 = 32'h0000_0012;
      in1 = 32'h0000_0000;
      in2 = 32'hA5A5_0003;
      clear_mem();
      dut.M[14'h3800] = 32'h0000_DEAD;

      put(32'h00, e_addi(5'd1, 5'd0, 32'd5),            32'd5,          0);
      put(32'h04, e_addi(5'd2, 5'd1, -32'sd1),          32'd4,          0);
      put(32'h08, e_csrw(12'h7C2, 5'd2),                32'd4,          0);
      put(32'h0C, e_addi(5'd3, 5'd0, 32'h7FF),          32'h7FF,        0);
      put(32'h10, e_addi(5'd3, 5'd3, 32'd1),            32'h800,        0);
      put(32'h14, e_addi(5'd4, 5'd0, -32'sd2048),       32'hFFFF_F800,  0);
      put(32'h18, e_addi(5'd0, 5'd0, 32'd9),            32'd9,          0);
      put(32'h1C, e_add(5'd5, 5'd0, 5'd0),              32'd0,          0);
      put(32'h20, e_csrr(5'd1, 12'hFC2),                32'h12,         0);
      put(32'h24, e_sw(5'd1, 5'd0, 32'h100),            32'd0,          1);
      put(32'h28, e_lw(5'd2, 5'd0, 32'h100),            32'h12,         0);
      put(32'h2C, e_mul(5'd6, 5'd2, 5'd4),              32'hFFFF_7000,  0);
      put(32'h30, e_csrr(5'd7, 12'hFC4),                32'hA5A5_0003,  0);
      put(32'h34, e_csrw(12'h7C4, 5'd7),                32'hA5A5_0003,  0);
      put(32'h38, e_csrw(12'h7C3, 5'd6),                32'hFFFF_7000,  0);
      put(32'h3C, e_csrr(5'd8, 12'hFC5),                32'd0,          1);
      put(32'h40, e_add(5'd9, 5'd8, 5'd0),              32'd0,          0);
      put(32'h44, e_lw(5'd10, 5'd4, 32'd0),             32'd0,          0);
      put(32'h48, e_sw(5'd7, 5'd4, 32'd0),              32'd0,          1);
      put(32'h4C, e_addi(5'd12, 5'd0, 32'd7),           32'd7,          0);
      put(32'h50, e_mul(5'd12, 5'd12, 5'd3),            32'h3800,       0);
      put(32'h54, e_lw(5'd13, 5'd12, 32'd0),            32'h0000_DEAD,  0);
      put(32'h58, e_jal(5'd14, 32'd8),                  32'h5C,         0);
      dut.M[14'h5C] = e_addi(5'd15, 5'd0, 32'd1);
      put(32'h60, e_addi(5'd15, 5'd0, 32'h6C),          32'h6C,         0);
      put(32'h64, e_jr(5'd15),                          32'd0,          1);
      dut.M[14'h68] = e_addi(5'd16, 5'd0, 32'd99);
      put(32'h6C, 32'hFFFF_FFFF,                        32'd0,          1);
      put(32'h70, e_addi(5'd16, 5'd0, 32'd2),           32'd2,          0);
      put(32'h74, e_add(5'd17, 5'd16, 5'd15),           32'h6E,         0);

      repeat (3) begin
         @(negedge clk);
         chk("rst.val",  {31'd0, trace_val}, 32'd0);
         chk("rst.addr", trace_addr, 32'd0);
         chk("rst.out0", out0, 32'd0);
         chk("rst.out1", out1, 32'd0);
         chk("rst.out2", out2, 32'd0);
      end
      rst = 1'b0;
      run_sb("p1");
      chk("p1.out0", out0, 32'd4);
      chk("p1.out1", out1, 32'hFFFF_7000);
      chk("p1.out2", out2, 32'hA5A5_0003);

      #2 rst = 1'b1;
      #1;
      chk("midrst.val",  {31'd0, trace_val}, 32'd0);
      chk("midrst.addr", trace_addr, 32'd0);
      chk("midrst.out0", out0, 32'd0);
      chk("midrst.out2", out2, 32'd0);
      chk("midrst.mem",  dut.M[14'h100], 32'h12);

      clear_mem();
      put(32'h00, e_addi(5'd1, 5'd0, 32'd3),     32'd3,  0);
      put(32'h04, e_addi(5'd1, 5'd1, -32'sd1),   32'd2,  0);
      put(32'h08, e_bne(5'd1, 5'd0, -32'sd4),    32'd0,  1);
      expect_trace(32'h04, e_addi(5'd1, 5'd1, -32'sd1), 32'd1, 0);
      expect_trace(32'h08, e_bne(5'd1, 5'd0, -32'sd4),  32'd0, 1);
      expect_trace(32'h04, e_addi(5'd1, 5'd1, -32'sd1), 32'd0, 0);
      expect_trace(32'h08, e_bne(5'd1, 5'd0, -32'sd4),  32'd0, 1);
      put(32'h0C, e_jal(5'd7, 32'd8),            32'h10, 0);
      dut.M[14'h10] = e_addi(5'd7, 5'd0, 32'd1);
      put(32'h14, e_csrw(12'h7C3, 5'd7),         32'h10, 0);

      @(negedge clk);
      rst = 1'b0;
      run_sb("p2");
      chk("p2.out1", out1, 32'h10);
      chk("p2.out0", out0, 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
